dct_mac_sequencer: RTL and testbench

// Control FSM for one DCT MAC unit (macu) inside dct_unit. Per accepted start it

---
 rtl/dct_mac_sequencer.sv | 126 ++++++++++++
 tb/tb_dct_mac_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: control FSM for one DCT MAC unit.
// Each accepted start issues TAPS multiply-accumulate steps. The first tap
// also clears the accumulator. The block then waits for the MAC pipeline,
// loads the result register, and holds result-valid until it is acknowledged.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation; a start is accepted here
// RUN   | one tap per cycle; mac_clr on tap 0; tap_idx = current tap
// DRAIN | MAC pipeline settling; res_ld pulses in the final drain cycle
// HOLD  | result valid; ack ends the op, ack+start begins the next op

module dct_mac_sequencer #(
   parameter int TAPS    = 8,
   parameter int CNT_W   = 3,
   parameter int MAC_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic             res_ack,
   output logic             busy,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [CNT_W-1:0] tap_idx,
   output logic             res_ld,
   output logic             res_vld,
   output logic             overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(TAPS - 1);
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(MAC_LAT - 1);

   state_t           state;
   logic [CNT_W-1:0] tap_cnt;
   // Drain timer counts down to zero. A value of zero marks the last drain cycle.
   logic [DRN_W-1:0] drain_cnt;

   // tap_cnt is a register. It holds the last tap outside RUN.
   assign tap_idx = tap_cnt;
   assign busy    = (state != IDLE);

   // Sequencer FSM. Each output is registered and set from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         tap_cnt   <= '0;
         drain_cnt <= '0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         res_ld    <= 1'b0;
         res_vld   <= 1'b0;
         overrun   <= 1'b0;
      end else if (!ena) begin
         // While frozen, pulse outputs are forced low and all other state holds.
         mac_clr <= 1'b0;
         mac_en  <= 1'b0;
         res_ld  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         mac_clr <= 1'b0;
         mac_en  <= 1'b0;
         res_ld  <= 1'b0;
         overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  tap_cnt <= '0;
                  mac_en  <= 1'b1;
                  mac_clr <= 1'b1;
               end
            end
            RUN: begin
               overrun <= start;
               if (tap_cnt == TAP_LAST) begin
                  state     <= DRAIN;
                  drain_cnt <= DRN_LOAD;
                  res_ld    <= (MAC_LAT == 1);
               end else begin
                  tap_cnt <= tap_cnt + CNT_W'(1);
                  mac_en  <= 1'b1;
               end
            end
            DRAIN: begin
               overrun <= start;
               if (drain_cnt == '0) begin
                  state   <= HOLD;
                  res_vld <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DRN_W'(1);
                  res_ld    <= (drain_cnt == DRN_W'(1));
               end
            end
            HOLD: begin
               if (res_ack) begin
                  res_vld <= 1'b0;
                  if (start) begin
                     state   <= RUN;
                     tap_cnt <= '0;
                     mac_en  <= 1'b1;
                     mac_clr <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  overrun <= start;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Testbench for dct_mac_sequencer (TAPS=8, MAC_LAT=2).
// The reference model tracks each operation as a progress count of enabled
// cycles since acceptance.

module tb_dct_mac_sequencer;

   localparam int TAPS    = 8;
   localparam int CNT_W   = 3;
   localparam int MAC_LAT = 2;
   localparam int DONE    = TAPS + MAC_LAT + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, ena, start, res_ack;
   logic             busy, mac_clr, mac_en, res_ld, res_vld, overrun;
   logic [CNT_W-1:0] tap_idx;

   dct_mac_sequencer #(.TAPS(TAPS), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .start   (start),
      .res_ack (res_ack),
      .busy    (busy),
      .mac_clr (mac_clr),
      .mac_en  (mac_en),
      .tap_idx (tap_idx),
      .res_ld  (res_ld),
      .res_vld (res_vld),
      .overrun (overrun)
   );

   bit m_active;
   int m_prog;
   int m_tap;
   bit e_busy, e_mac_clr, e_mac_en, e_res_ld, e_res_vld, e_overrun;

   int n_pass, n_fail, n_total;
   int cyc, ld_cyc, ld_cnt, ovr_cnt, s0, first_ld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      bit waiting, acc, fin;
      if (!rst) begin
         m_active  = 1'b0;
         m_prog    = 0;
         m_tap     = 0;
         e_busy    = 1'b0;
         e_mac_clr = 1'b0;
         e_mac_en  = 1'b0;
         e_res_ld  = 1'b0;
         e_res_vld = 1'b0;
         e_overrun = 1'b0;
      end else if (!ena) begin
         e_mac_clr = 1'b0;
         e_mac_en  = 1'b0;
         e_res_ld  = 1'b0;
         e_overrun = 1'b0;
      end else begin
         waiting = m_active && (m_prog >= DONE);
         acc     = start && (!m_active || (waiting && res_ack));
         fin     = waiting && res_ack && !start;
         if (acc) begin
            m_active = 1'b1;
            m_prog   = 1;
         end else if (fin) begin
            m_active = 1'b0;
            m_prog   = 0;
         end else if (m_active && m_prog < DONE) begin
            m_prog++;
         end
         e_busy    = m_active;
         e_mac_en  = m_active && m_prog >= 1 && m_prog <= TAPS;
         e_mac_clr = m_active && m_prog == 1;
         if (e_mac_en) m_tap = m_prog - 1;
         e_res_ld  = m_active && m_prog == TAPS + MAC_LAT;
         e_res_vld = m_active && m_prog >= DONE;
         e_overrun = start && !acc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      if (res_ld === 1'b1) begin
         ld_cyc = cyc;
         ld_cnt++;
      end
      if (overrun === 1'b1) ovr_cnt++;
      chk("busy",    {31'b0, busy},    {31'b0, e_busy});
      chk("mac_clr", {31'b0, mac_clr}, {31'b0, e_mac_clr});
      chk("mac_en",  {31'b0, mac_en},  {31'b0, e_mac_en});
      chk("tap_idx", {29'b0, tap_idx}, 32'(m_tap));
      chk("res_ld",  {31'b0, res_ld},  {31'b0, e_res_ld});
      chk("res_vld", {31'b0, res_vld}, {31'b0, e_res_vld});
      chk("overrun", {31'b0, overrun}, {31'b0, e_overrun});
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      cyc = 0; ld_cyc = 0; ld_cnt = 0; ovr_cnt = 0;
      rst = 1'b0; ena = 1'b1; start = 1'b0; res_ack = 1'b0;

      // Reset: reset state, then abort in mid-RUN. Reset also wins over ena=0.
      tick(); tick();
      rst = 1'b1; start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      rst = 1'b0; ena = 1'b0; tick(); ena = 1'b1; tick();
      rst = 1'b1; ld_cnt = 0;
      repeat (14) tick();
      chk("no_ld_after_abort", 32'(ld_cnt), 32'd0);

      // Single operation with the ack held off.
      s0 = cyc; start = 1'b1; tick(); start = 1'b0;
      repeat (13) tick();
      chk("ld_latency", 32'(ld_cyc - s0), 32'd10);
      res_ack = 1'b1; tick(); res_ack = 1'b0; tick();

      // Back-to-back: ack together with start in the first HOLD cycle.
      s0 = cyc; start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      first_ld = ld_cyc;
      res_ack = 1'b1; start = 1'b1; tick(); res_ack = 1'b0; start = 1'b0;
      repeat (14) tick();
      chk("b2b_spacing", 32'(ld_cyc - first_ld), 32'd11);
      res_ack = 1'b1; tick(); res_ack = 1'b0; tick();

      // Overrun: start during RUN (cycle 4), and start in HOLD without ack.
      ovr_cnt = 0; ld_cnt = 0;
      s0 = cyc; start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (7) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      chk("ovr_count", 32'(ovr_cnt), 32'd2);
      chk("ovr_ld_latency", 32'(ld_cyc - s0), 32'd10);
      res_ack = 1'b1; tick(); res_ack = 1'b0;
      repeat (12) tick();
      chk("ovr_single_ld", 32'(ld_cnt), 32'd1);

      // Enable stall: three frozen cycles while tap 5 is presented.
      s0 = cyc; start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      chk("stall_tap_before", {29'b0, tap_idx}, 32'd5);
      ena = 1'b0;
      repeat (3) tick();
      chk("stall_tap_hold", {29'b0, tap_idx}, 32'd5);
      chk("stall_mac_en", {31'b0, mac_en}, 32'd0);
      ena = 1'b1;
      repeat (10) tick();
      chk("stall_ld_latency", 32'(ld_cyc - s0), 32'd13);
      res_ack = 1'b1; tick(); res_ack = 1'b0; tick();

      // Stray acks in IDLE, RUN and DRAIN are ignored.
      res_ack = 1'b1; tick(); res_ack = 1'b0;
      chk("stray_idle_busy", {31'b0, busy}, 32'd0);
      s0 = cyc; start = 1'b1; tick(); start = 1'b0;
      tick();
      res_ack = 1'b1; tick(); res_ack = 1'b0;
      repeat (5) tick();
      res_ack = 1'b1; tick(); tick(); tick(); res_ack = 1'b0;
      repeat (2) tick();
      chk("stray_ld_latency", 32'(ld_cyc - s0), 32'd10);
      chk("stray_vld_held", {31'b0, res_vld}, 32'd1);
      res_ack = 1'b1; tick(); res_ack = 1'b0; tick();

      // Randomised traffic against the reference model.
      repeat (800) begin
         rst     = ($urandom_range(0, 99) != 0);
         ena     = ($urandom_range(0, 9) != 0);
         start   = ($urandom_range(0, 3) == 0);
         res_ack = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
